// File: rtl/sonic_eth_pause_pkg.sv
// Shared 802.3x PAUSE definitions for the RX pause decoder and the TX pause generator.
// Word offsets count 64-bit beats after SOP, first byte on [63:56].
package sonic_eth_pause_pkg;

    localparam logic [15:0] PAUSE_ETYPE      = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE     = 16'h0001;
    localparam logic [47:0] PAUSE_DA_DEFAULT = 48'h0180C2000001;

    // DA in [63:16] of word 0, EtherType/opcode in [31:0] of word 1, quanta in [63:48] of word 2
    localparam int WORD_DA     = 0;
    localparam int WORD_ETYPE  = 1;
    localparam int WORD_QUANTA = 2;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_W1,
        PS_W2,
        PS_TAIL,
        PS_DROP
    } pause_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        error;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } st_beat_t;

endpackage

// File: rtl/sonic_v1_15_st_pipe_stage.sv
// One-deep Avalon-ST register stage: 1-cycle latency, full throughput while out_ready is high,
// payload held stable while stalled.
module sonic_v1_15_st_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         in_ready,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_payload
);

    assign in_ready = out_ready | ~out_valid;

    // NOTE: the payload register is reset along with out_valid so every out_* reads 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (in_valid && in_ready) begin
            // NOTE: clocked state uses <= so every register samples pre-edge values.
            out_valid   <= 1'b1;
            out_payload <= in_payload;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/blk_fb76cb.sv
// RX pause-control decoder: forwards the MAC RX stream through one register stage and
// recognises 802.3x PAUSE frames, reporting quanta and pause statistics.
module blk_fb76cb
    import sonic_eth_pause_pkg::*;
#(
    parameter int          ERR_W    = 2,
    parameter int          CNT_W    = 32,
    parameter bit          DA_CHECK = 1'b1,
    parameter logic [47:0] PAUSE_DA = PAUSE_DA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic [ERR_W-1:0] in_error,
    input  logic             in_startofpacket,
    input  logic             in_endofpacket,
    input  logic [2:0]       in_empty,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic             out_error,
    output logic             out_startofpacket,
    output logic             out_endofpacket,
    output logic [2:0]       out_empty,
    output logic             pause_valid,
    output logic [15:0]      pause_quanta,
    output logic [CNT_W-1:0] pause_frame_cnt,
    output logic [CNT_W-1:0] pause_err_cnt
);

    st_beat_t in_beat;
    st_beat_t out_beat;

    assign in_beat = '{data:  in_data,
                       error: |in_error,
                       sop:   in_startofpacket,
                       eop:   in_endofpacket,
                       empty: in_empty};

    sonic_v1_15_st_pipe_stage #(
        .W($bits(st_beat_t))
    ) u_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_ready    (in_ready),
        .in_valid    (in_valid),
        .in_payload  (in_beat),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_payload (out_beat)
    );

    assign out_data          = out_beat.data;
    assign out_error         = out_beat.error;
    assign out_startofpacket = out_beat.sop;
    assign out_endofpacket   = out_beat.eop;
    assign out_empty         = out_beat.empty;

    pause_state_t state, state_nxt;
    logic [15:0]  quanta_cand;
    logic         accept;
    logic         da_ok;
    logic         type_ok;
    logic         capture;
    logic         pulse;
    logic         err_inc;

    assign accept  = in_valid & in_ready;
    assign da_ok   = !DA_CHECK || (in_data[63:16] == PAUSE_DA);
    assign type_ok = (in_data[31:16] == PAUSE_ETYPE) && (in_data[15:0] == PAUSE_OPCODE);

    // A SOP beat always restarts parsing as word 0, whatever frame was in progress.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_nxt = state;
        capture   = 1'b0;
        pulse     = 1'b0;
        err_inc   = 1'b0;
        if (accept) begin
            if (in_startofpacket) begin
                if (in_endofpacket) begin
                    state_nxt = PS_IDLE;
                    err_inc   = da_ok;
                end else begin
                    state_nxt = da_ok ? PS_W1 : PS_DROP;
                end
            end else begin
                unique case (state)
                    PS_IDLE: state_nxt = PS_IDLE;
                    PS_W1: begin
                        if (in_endofpacket) begin
                            state_nxt = PS_IDLE;
                            err_inc   = type_ok;
                        end else begin
                            state_nxt = type_ok ? PS_W2 : PS_DROP;
                        end
                    end
                    PS_W2: begin
                        if (in_endofpacket) begin
                            state_nxt = PS_IDLE;
                            err_inc   = 1'b1;
                        end else begin
                            state_nxt = PS_TAIL;
                            capture   = 1'b1;
                        end
                    end
                    PS_TAIL: begin
                        if (in_endofpacket) begin
                            state_nxt = PS_IDLE;
                            pulse     = ~|in_error;
                            err_inc   = |in_error;
                        end
                    end
                    PS_DROP: begin
                        if (in_endofpacket) state_nxt = PS_IDLE;
                    end
                    default: state_nxt = PS_IDLE;
                endcase
            end
        end
    end

    // Pulse and counters update on the EOP accept edge, i.e. when that beat first shows on out_*.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= PS_IDLE;
            quanta_cand     <= '0;
            pause_valid     <= 1'b0;
            pause_quanta    <= '0;
            pause_frame_cnt <= '0;
            pause_err_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            pause_valid <= pulse;
            if (capture) quanta_cand <= in_data[63:48];
            if (pulse) begin
                pause_quanta <= quanta_cand;
                if (pause_frame_cnt != '1) pause_frame_cnt <= pause_frame_cnt + 1'b1;
            end
            if (err_inc && (pause_err_cnt != '1)) pause_err_cnt <= pause_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_blk_fb76cb.sv
// Scoreboard bench for blk_fb76cb: a frame-level PAUSE model predicts pulses and counters,
// a negedge monitor checks every forwarded beat and every pause pulse.
module tb_blk_fb76cb;

    localparam logic [47:0] CTRL_DA = 48'h0180C2000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_ready, in_valid;
    logic [63:0] in_data;
    logic [1:0]  in_error;
    logic        in_sop, in_eop;
    logic [2:0]  in_empty;
    logic        out_ready, out_valid;
    logic [63:0] out_data;
    logic        out_error, out_sop, out_eop;
    logic [2:0]  out_empty;
    logic        pause_valid;
    logic [15:0] pause_quanta;
    logic [31:0] pause_frame_cnt, pause_err_cnt;

    always #5 clk = ~clk;

    blk_fb76cb dut (
        .clk               (clk),
        .reset_n           (rst_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
        .pause_valid       (pause_valid),
        .pause_quanta      (pause_quanta),
        .pause_frame_cnt   (pause_frame_cnt),
        .pause_err_cnt     (pause_err_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        int          cyc;
        bit          lat;
    } exp_beat_t;

    exp_beat_t   exp_beats[$];
    logic [15:0] exp_quanta[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    bit          stall_mode = 1'b0;
    logic [31:0] m_frames, m_errs;
    logic [15:0] m_last_q;
    logic [63:0] fw[16];
    int          fn;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sink side: random backpressure only while stall_mode is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: one pop per transferred beat, one pop per pause pulse.
    always @(negedge clk) begin : monitor
        exp_beat_t   e;
        logic [15:0] q;
        if (rst_n && out_valid && out_ready) begin
            if (exp_beats.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_beats.pop_front();
                check("out_data", out_data, e.data);
                check("out_error", out_error, e.err);
                check("out_sop", out_sop, e.sop);
                check("out_eop", out_eop, e.eop);
                check("out_empty", out_empty, e.empty);
                if (e.lat) check("latency", cyc, e.cyc);
            end
        end
        if (rst_n && pause_valid) begin
            check("pulse_on_eop_beat", {out_valid, out_eop}, 2'b11);
            if (exp_quanta.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                q = exp_quanta.pop_front();
                check("pulse_quanta", pause_quanta, q);
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [1:0] e, input bit s, input bit eo,
                             input logic [2:0] em);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_error = e;
        in_sop   = s;
        in_eop   = eo;
        in_empty = em;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else exp_beats.push_back('{d, |e, s, eo, em, cyc, !stall_mode});
        in_valid = 1'b0;
    endtask

    // Frame-level reference: classify a whole frame by its header words and length.
    task automatic model_frame(input logic [1:0] eop_err);
        bit da_ok, type_ok;
        da_ok   = (fw[0][63:16] == CTRL_DA);
        type_ok = (fn >= 2) && (fw[1][31:16] == 16'h8808) && (fw[1][15:0] == 16'h0001);
        if (da_ok && (fn < 2 || type_ok)) begin
            if (fn <= 3 || eop_err != 2'b00) begin
                m_errs++;
            end else begin
                exp_quanta.push_back(fw[2][63:48]);
                m_last_q = fw[2][63:48];
                m_frames++;
            end
        end
    endtask

    task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                         input logic [15:0] q, input int n);
        fn = n;
        for (int i = 0; i < 16; i++) fw[i] = {$urandom, $urandom};
        fw[0][63:16] = da;
        fw[1][31:16] = et;
        fw[1][15:0]  = op;
        fw[2][63:48] = q;
    endtask

    task automatic send_frame(input logic [1:0] eop_err, input bit noise, input bit complete,
                              input bit model);
        logic [1:0] e;
        logic [2:0] em;
        bit         last;
        for (int i = 0; i < fn; i++) begin
            last = complete && (i == fn - 1);
            e    = last ? eop_err : (noise ? 2'($urandom_range(0, 3)) : 2'b00);
            em   = (last && noise) ? 3'($urandom_range(0, 7)) : 3'd0;
            send_beat(fw[i], e, i == 0, last, em);
        end
        if (model) model_frame(eop_err);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_beats.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check("drain_beats_left", exp_beats.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        check("pause_frame_cnt", pause_frame_cnt, m_frames);
        check("pause_err_cnt", pause_err_cnt, m_errs);
        check("pulses_missing", exp_quanta.size(), 0);
        check("pause_quanta_held", pause_quanta, m_last_q);
    endtask

    task automatic check_all_zero();
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", {out_valid, out_error, out_sop, out_eop, out_empty}, 0);
        check("rst_pause", {pause_valid, pause_quanta}, 0);
        check("rst_counters", {pause_frame_cnt, pause_err_cnt}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_error = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
        m_frames = 0;
        m_errs   = 0;
        m_last_q = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean 64-byte PAUSE, quanta 0x00FF
        build(CTRL_DA, 16'h8808, 16'h0001, 16'h00FF, 8);
        send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts();

        // 2: same frame with an error on EOP
        send_frame(2'b10, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts();

        // 3: non-PAUSE EtherType, then a 2-beat runt PAUSE header
        build(CTRL_DA, 16'h0800, 16'h0001, 16'h5555, 8);
        send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        build(CTRL_DA, 16'h8808, 16'h0001, 16'h0000, 2);
        send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts();

        // 4: 100 back-to-back PAUSE frames under random backpressure
        stall_mode = 1'b1;
        for (int q = 0; q < 100; q++) begin
            build(CTRL_DA, 16'h8808, 16'h0001, 16'(q), 8);
            send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        end
        stall_mode = 1'b0;
        drain();
        check_counts();

        // 5: frame abandoned after W1 by a new SOP, then a full PAUSE 0x1234
        build(CTRL_DA, 16'h8808, 16'h0001, 16'hAAAA, 2);
        send_frame(2'b00, 1'b0, 1'b0, 1'b0);
        build(CTRL_DA, 16'h8808, 16'h0001, 16'h1234, 8);
        send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts();

        // 6: reset pulse while the parser sits in W2, tail of that frame after release
        build(CTRL_DA, 16'h8808, 16'h0001, 16'h7777, 8);
        send_beat(fw[0], 2'b00, 1'b1, 1'b0, 3'd0);
        send_beat(fw[1], 2'b00, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b0;
        exp_beats.delete();
        exp_quanta.delete();
        m_frames = 0;
        m_errs   = 0;
        m_last_q = 0;
        @(negedge clk);
        check_all_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 2; i < 8; i++) send_beat(fw[i], 2'b00, 1'b0, i == 7, 3'd0);
        drain();
        check_counts();
        build(CTRL_DA, 16'h8808, 16'h0001, 16'h0000, 8);
        send_frame(2'b00, 1'b0, 1'b1, 1'b1);
        drain();
        check_counts();

        // 7: random mix of lengths, DAs, EtherTypes and errors under backpressure
        stall_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            build(($urandom_range(0, 3) != 0) ? CTRL_DA : {$urandom, 16'h0000},
                  ($urandom_range(0, 3) != 0) ? 16'h8808 : 16'h0800,
                  16'h0001, 16'($urandom), $urandom_range(1, 9));
            send_frame(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       1'b1, 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        stall_mode = 1'b0;
        drain();
        check_counts();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
